// File: rtl/rtf65002_pkg.sv
// Shared rtf65002 definitions: instruction-cache fill states and line geometry.
package rtf65002_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOK   = 2'd1,
        FETCH  = 2'd2,
        SETTLE = 2'd3
    } ifill_state_t;

    localparam int LINE_BYTES    = 16;
    localparam int BEATS         = 4;
    localparam int BEAT_W        = $clog2(BEATS);
    localparam int LINE_W        = 32 - $clog2(LINE_BYTES);
    localparam int SETTLE_CYCLES = 2;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES);

    // Line number of (pc + 8): adding 8 carries into the line field exactly when pc[3] is set.
    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] line,
                                                    input logic half);
        return line + {{(LINE_W-1){1'b0}}, half};
    endfunction

endpackage

// File: rtl/rtf65002_icachefill.sv
// Instruction-cache miss handler: checks the pc and pc+8 lines, then bursts a 16-byte
// line from the bus into the cache with round-robin way selection.
module rtf65002_icachefill
    import rtf65002_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_i,
    input  logic        hit0_i,
    input  logic        hit1_i,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic        err_i,
    output logic [33:0] badr_o,
    input  logic [31:0] dat_i,
    output logic        wr_o,
    output logic        whichwr_o,
    output logic [33:0] adr_o,
    output logic [31:0] dat_o,
    output logic        busy_o,
    output logic        err_o
);

    ifill_state_t          state;
    ifill_state_t          state_nx;
    logic [31:0]           lpc;
    logic [LINE_W-1:0]     line;
    logic [BEAT_W-1:0]     beat;
    logic                  way;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  last_beat;
    logic                  settle_done;
    logic                  unused_lpc_lsbs;

    assign last_beat       = (beat == BEAT_W'(BEATS - 1));
    assign settle_done     = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign whichwr_o       = way;
    assign unused_lpc_lsbs = ^lpc[2:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            beat       <= '0;
            way        <= 1'b0;
            settle_cnt <= '0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nx;
            err_o <= (state == FETCH) && err_i;
            case (state)
                IDLE: begin
                    if (en_i)
                        lpc <= pc_i;
                end
                LOOK: begin
                    beat <= '0;
                    if (!hit0_i)
                        line <= lpc[31:4];
                    else if (!hit1_i)
                        line <= next_line(lpc[31:4], lpc[3]);
                end
                FETCH: begin
                    settle_cnt <= '0;
                    // A bus error wins over a simultaneous ack; the way is only advanced by a complete line.
                    if (err_i) begin
                        beat <= '0;
                    end else if (ack_i) begin
                        beat <= beat + 1'b1;
                        if (last_beat)
                            way <= ~way;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_done) begin
                        settle_cnt <= '0;
                        lpc        <= pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        cyc_o    = 1'b0;
        stb_o    = 1'b0;
        wr_o     = 1'b0;
        badr_o   = '0;
        adr_o    = '0;
        dat_o    = '0;
        busy_o   = (state != IDLE);
        case (state)
            IDLE: begin
                if (en_i)
                    state_nx = LOOK;
            end
            LOOK: begin
                // Both lines missing: the pc line goes first, pc+8 is caught on the next pass.
                if (!hit0_i || !hit1_i)
                    state_nx = FETCH;
                else
                    state_nx = IDLE;
            end
            FETCH: begin
                cyc_o  = 1'b1;
                stb_o  = 1'b1;
                badr_o = {2'b00, line, beat, 2'b00};
                if (err_i) begin
                    state_nx = IDLE;
                end else if (ack_i) begin
                    wr_o  = 1'b1;
                    // Bit 0 doubles as the tag valid bit; tag RAMs only latch on the last beat.
                    adr_o = {badr_o[33:1], last_beat};
                    dat_o = dat_i;
                    if (last_beat)
                        state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done)
                    state_nx = LOOK;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rtf65002_icachefill.sv
// Self-checking bench for rtf65002_icachefill: scoreboarded cache writes per fill scenario.
module tb_rtf65002_icachefill;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        hit0_i = 1'b1;
    logic        hit1_i = 1'b1;
    logic        cyc_o, stb_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [33:0] badr_o;
    logic [31:0] dat_i = '0;
    logic        wr_o, whichwr_o;
    logic [33:0] adr_o;
    logic [31:0] dat_o;
    logic        busy_o, err_o;

    always #5 clk = ~clk;

    rtf65002_icachefill dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pc_i(pc_i),
        .hit0_i(hit0_i), .hit1_i(hit1_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i),
        .badr_o(badr_o), .dat_i(dat_i),
        .wr_o(wr_o), .whichwr_o(whichwr_o), .adr_o(adr_o), .dat_o(dat_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [33:0] adr;
        logic [31:0] dat;
        logic        way;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // err_beat = 4 means no bus error during the fill.
    task automatic do_fill(input string name, input logic [31:0] pc, input logic h0, input logic h1,
                           input int waits, input int err_beat, input logic err_with_ack,
                           input logic [27:0] exp_line, input logic exp_way);
        wr_exp_t e;
        int bi = 0, w = 0, cur = 0, nwr = 0, ntag = 0, nerr = 0, post_busy = 0;
        int nbeats;
        logic cyc_seen = 1'b0;
        logic done = 1'b0;
        logic err_now;
        nbeats = (err_beat < 4) ? err_beat : 4;
        for (int b = 0; b < nbeats; b++) begin
            e.adr = {2'b00, exp_line, 2'(b), 2'b00} | ((b == 3) ? 34'd1 : 34'd0);
            e.dat = $urandom;
            e.way = exp_way;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        pc_i = pc; hit0_i = h0; hit1_i = h1; en_i = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b1) begin
            bad++; $display("FAIL %s look_busy: got %b want 1", name, busy_o);
        end
        for (int t = 0; t < 120 && !done; t++) begin
            @(posedge clk); #1;
            ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom; err_now = 1'b0;
            cur = bi;
            if (cyc_o) begin
                cyc_seen = 1'b1; hit0_i = 1'b1; hit1_i = 1'b1;
                if (w < waits) begin
                    w++;
                end else begin
                    w = 0;
                    if (bi == err_beat) begin
                        err_i = 1'b1; ack_i = err_with_ack; err_now = 1'b1;
                    end else begin
                        ack_i = 1'b1;
                        if (exp_q.size() > 0) dat_i = exp_q[0].dat;
                    end
                    bi++;
                end
            end
            @(negedge clk);
            if (cyc_o) begin
                total++;
                if (badr_o !== {2'b00, exp_line, 2'(cur), 2'b00} || stb_o !== 1'b1 || whichwr_o !== exp_way) begin
                    bad++;
                    $display("FAIL %s bus_beat%0d: got badr=%h stb=%b way=%b want badr=%h stb=1 way=%b",
                             name, cur, badr_o, stb_o, whichwr_o, {2'b00, exp_line, 2'(cur), 2'b00}, exp_way);
                end
            end
            if (err_now) begin
                total++;
                if (wr_o !== 1'b0) begin
                    bad++; $display("FAIL %s wr_on_err: got %b want 0", name, wr_o);
                end
            end
            if (wr_o === 1'b1) begin
                nwr++;
                if (adr_o[3:2] == 2'b11 && adr_o[0]) ntag++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL %s extra_write: got adr=%h want no write", name, adr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (adr_o !== e.adr || dat_o !== e.dat || whichwr_o !== e.way) begin
                        bad++;
                        $display("FAIL %s cache_write: got adr=%h dat=%h way=%b want adr=%h dat=%h way=%b",
                                 name, adr_o, dat_o, whichwr_o, e.adr, e.dat, e.way);
                    end
                end
            end
            if (err_o === 1'b1) nerr++;
            if (cyc_seen && !cyc_o && busy_o) post_busy++;
            if (cyc_seen && !busy_o) done = 1'b1;
        end
        ack_i = 1'b0; err_i = 1'b0;
        total++;
        if (!done) begin
            bad++; $display("FAIL %s timeout: got busy=%b cyc_seen=%b want fill to finish", name, busy_o, cyc_seen);
        end
        total++;
        if (nwr != nbeats) begin
            bad++; $display("FAIL %s write_count: got %0d want %0d", name, nwr, nbeats);
        end
        total++;
        if (ntag != ((err_beat < 4) ? 0 : 1)) begin
            bad++; $display("FAIL %s tag_writes: got %0d want %0d", name, ntag, (err_beat < 4) ? 0 : 1);
        end
        total++;
        if (nerr != ((err_beat < 4) ? 1 : 0)) begin
            bad++; $display("FAIL %s err_pulse_cycles: got %0d want %0d", name, nerr, (err_beat < 4) ? 1 : 0);
        end
        if (err_beat >= 4) begin
            total++;
            if (post_busy != 3) begin
                bad++; $display("FAIL %s settle_look_cycles: got %0d want 3", name, post_busy);
            end
        end
        total++;
        if (whichwr_o !== ((err_beat < 4) ? exp_way : ~exp_way)) begin
            bad++; $display("FAIL %s way_after: got %b want %b", name, whichwr_o, (err_beat < 4) ? exp_way : ~exp_way);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL %s missing_writes: got %0d left want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; pc_i = 32'h0000_1000; hit0_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cyc_o, stb_o, wr_o, whichwr_o, busy_o, err_o} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {cyc_o, stb_o, wr_o, whichwr_o, busy_o, err_o});
        end
        total++;
        if (badr_o !== 34'd0 || adr_o !== 34'd0 || dat_o !== 32'd0) begin
            bad++; $display("FAIL reset_data: got badr=%h adr=%h dat=%h want 0", badr_o, adr_o, dat_o);
        end
        @(posedge clk); #1;
        en_i = 1'b0; hit0_i = 1'b1; rst_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_stray_ack();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ack_i = 1'b1; dat_i = $urandom;
            @(negedge clk);
            total++;
            if (wr_o !== 1'b0 || cyc_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++; $display("FAIL stray_ack: got wr=%b cyc=%b busy=%b want 0 0 0", wr_o, cyc_o, busy_o);
            end
        end
        @(posedge clk); #1;
        ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int n = 0;
        @(posedge clk); #1;
        pc_i = 32'h0000_5000; hit0_i = 1'b0; hit1_i = 1'b1; en_i = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        while (!cyc_o && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (cyc_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_start: got cyc=%b want 1", cyc_o);
        end
        ack_i = 1'b1; dat_i = 32'hA5A5_0000;
        @(negedge clk);
        total++;
        if (wr_o !== 1'b1 || adr_o !== 34'h0_0000_5000 || dat_o !== 32'hA5A5_0000) begin
            bad++; $display("FAIL rst_mid_beat0: got wr=%b adr=%h dat=%h want 1 5000 a5a50000", wr_o, adr_o, dat_o);
        end
        @(posedge clk); #1;
        ack_i = 1'b0; rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (cyc_o !== 1'b1 || badr_o !== 34'h0_0000_5004) begin
            bad++; $display("FAIL rst_mid_beat1: got cyc=%b badr=%h want 1 5004", cyc_o, badr_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if ({cyc_o, stb_o, wr_o, whichwr_o, busy_o, err_o} !== 6'b0 ||
            badr_o !== 34'd0 || adr_o !== 34'd0 || dat_o !== 32'd0) begin
            bad++; $display("FAIL rst_mid_outputs: got ctrl=%b badr=%h adr=%h dat=%h want all 0",
                            {cyc_o, stb_o, wr_o, whichwr_o, busy_o, err_o}, badr_o, adr_o, dat_o);
        end
        hit0_i = 1'b1;
        do_fill("rst_refill", 32'h0000_5000, 1'b0, 1'b1, 0, 4, 1'b0, 28'h0000500, 1'b0);
    endtask

    initial begin
        test_reset();
        do_fill("fill_pc",      32'h0000_1000, 1'b0, 1'b1, 0, 4, 1'b0, 28'h0000100, 1'b0);
        do_fill("second_fill",  32'h0000_3000, 1'b0, 1'b1, 0, 4, 1'b0, 28'h0000300, 1'b1);
        do_fill("fill_pc8",     32'h0000_1008, 1'b1, 1'b0, 0, 4, 1'b0, 28'h0000101, 1'b0);
        do_fill("err_beat2",    32'h0000_6000, 1'b0, 1'b1, 0, 2, 1'b1, 28'h0000600, 1'b1);
        do_fill("err_beat0",    32'h0000_6000, 1'b0, 1'b1, 0, 0, 1'b0, 28'h0000600, 1'b1);
        do_fill("wait_states",  32'h0000_2000, 1'b0, 1'b1, 2, 4, 1'b0, 28'h0000200, 1'b1);
        do_fill("wrap",         32'hFFFF_FFF8, 1'b1, 1'b0, 0, 4, 1'b0, 28'h0000000, 1'b0);
        do_fill("both_miss",    32'h0000_4008, 1'b0, 1'b0, 1, 4, 1'b0, 28'h0000400, 1'b1);
        test_stray_ack();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
